// File: rtl/frame_byte_sequencer_pkg.sv
// frame_byte_sequencer_pkg: shared widths, slot limits, terminator byte and FSM encoding
// Optional feature macro: FRAME_BYTE_SEQ_CHECKSUM_EN (adds a trailing XOR checksum slot)
package frame_byte_sequencer_pkg;
  localparam int BYTE_W = 8;
  localparam int SEL_W = 4;
  localparam logic [SEL_W-1:0] LAST_SEL = 4'd10;
  localparam logic [BYTE_W-1:0] TERM_BYTE = 8'hB7;
`ifdef FRAME_BYTE_SEQ_CHECKSUM_EN
  localparam logic [SEL_W-1:0] FINAL_IDX = LAST_SEL + 4'd1;
`else
  localparam logic [SEL_W-1:0] FINAL_IDX = LAST_SEL;
`endif
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    PRESENT = 2'd2,
    DONE    = 2'd3
  } state_e;
endpackage

// File: rtl/frame_byte_sequencer.sv
// frame_byte_sequencer: walks a byte-mux select 0..10 and streams each fetched byte on valid/ready
// Ports: Clock/Reset (sync, active-high); Start/Abort control; Sel -> mux select, ByteIn <- mux data;
//   OutByte/OutValid/OutReady consumer handshake; Busy (not IDLE); Done (one-cycle end-of-frame pulse).
// Macro FRAME_BYTE_SEQ_CHECKSUM_EN appends an XOR checksum of bytes 0..9 after the terminator.
module frame_byte_sequencer
  import frame_byte_sequencer_pkg::*;
(
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Abort,
  output logic [SEL_W-1:0]  Sel,
  input  logic [BYTE_W-1:0] ByteIn,
  output logic [BYTE_W-1:0] OutByte,
  output logic              OutValid,
  input  logic              OutReady,
  output logic              Busy,
  output logic              Done
);
  state_e state_q, state_d;
  logic [SEL_W-1:0] index_q, index_d;
  logic [BYTE_W-1:0] out_byte_q, out_byte_d;
  logic out_valid_q, out_valid_d;
  logic hs;
  assign hs = state_q == PRESENT && out_valid_q && OutReady;
  // the checksum slot sits past the terminator but keeps the mux parked on slot 10
  assign Sel = (state_q == FETCH || state_q == PRESENT) ? ((index_q > LAST_SEL) ? LAST_SEL : index_q) : '0;
  assign OutByte = out_byte_q;
  assign OutValid = out_valid_q;
  assign Busy = state_q != IDLE;
  assign Done = state_q == DONE;
`ifdef FRAME_BYTE_SEQ_CHECKSUM_EN
  logic [BYTE_W-1:0] csum_q, csum_d;
  assign csum_d = (state_q == IDLE && Start) ? '0 : (hs && index_q < LAST_SEL) ? csum_q ^ out_byte_q : csum_q;
  always_ff @(posedge Clock) csum_q <= Reset ? '0 : csum_d;
`endif
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    out_byte_d = out_byte_q;
    out_valid_d = out_valid_q;
    if (Abort && state_q != IDLE) begin
      state_d = IDLE;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (Start) begin
          index_d = '0;
          state_d = FETCH;
        end
        FETCH: begin
          out_byte_d = ByteIn;
          out_valid_d = 1'b1;
          state_d = PRESENT;
        end
        PRESENT: if (hs) begin
`ifdef FRAME_BYTE_SEQ_CHECKSUM_EN
          // checksum needs no mux settling, so it is presented straight after the terminator
          if (index_q == LAST_SEL) begin
            out_byte_d = csum_q;
            index_d = FINAL_IDX;
          end else
`endif
          begin
            out_valid_d = 1'b0;
            index_d = (index_q == FINAL_IDX) ? index_q : index_q + 4'd1;
            state_d = (index_q == FINAL_IDX) ? DONE : FETCH;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      index_q <= '0;
      out_byte_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      out_byte_q <= out_byte_d;
      out_valid_q <= out_valid_d;
    end
  end
endmodule
